spm_xfer_engine: RTL and testbench

Block-transfer engine driving port B of the scratch-pad memory (SPM) dual-port RAM while the CPU pipeline owns port A. Software programs source, destination, count and mode through a four-register slave interface. The engine then either copies a word range inside the SPM or fills a range with a constant, and raises a done flag and an optional interrupt. It sits directly upstream of the SPM RAM's port B and consumes that port's registered read data.

---
 rtl/spm_xfer_engine.sv | 159 +++++++++++++++
 tb/tb_spm_xfer_engine.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_xfer_engine.sv
// SPM port-B block-transfer engine: word copy or constant fill,
// programmed through a four-register slave port.
module spm_xfer_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_cs,
    input  logic              reg_we,
    input  logic [1:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_we,
    output logic [DATA_W-1:0] spm_wdata,
    input  logic [DATA_W-1:0] spm_rdata,
    output logic              busy,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, RD, WR, FILL} state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   cnt_q;
    logic              mode_q, irq_en_q, done_q;
    logic [ADDR_W-1:0] sptr_q, sptr_d, dptr_q, dptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] addr_d;
    logic              we_d;
    logic              wr, ctrl_wr, start, abort, go, fin;

    assign busy    = (state_q != IDLE);
    assign wr      = reg_cs & reg_we;
    assign ctrl_wr = wr && (reg_addr == 2'd0);
    assign start   = ctrl_wr & reg_wdata[0] & ~busy;
    assign abort   = ctrl_wr & reg_wdata[4] & busy;
    assign go      = start && (cnt_q != '0);
    assign irq     = done_q & irq_en_q;

    assign spm_wdata = (state_q == FILL) ? src_q : spm_rdata;

    always_comb begin
        state_d = state_q;
        sptr_d  = sptr_q;
        dptr_d  = dptr_q;
        rem_d   = rem_q;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    sptr_d  = src_q[ADDR_W-1:0];
                    dptr_d  = dst_q;
                    rem_d   = cnt_q;
                    state_d = reg_wdata[1] ? FILL : RD;
                end
            end
            RD: state_d = WR;
            WR: begin
                sptr_d = sptr_q + PTR_ONE;
                dptr_d = dptr_q + PTR_ONE;
                rem_d  = rem_q - REM_ONE;
                if (rem_q == REM_ONE) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end else begin
                    state_d = RD;
                end
            end
            FILL: begin
                dptr_d = dptr_q + PTR_ONE;
                rem_d  = rem_q - REM_ONE;
                if (rem_q == REM_ONE) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Port outputs are registered, so derive them from the next state.
    always_comb begin
        addr_d = spm_addr;
        we_d   = 1'b0;
        unique case (state_d)
            RD:      addr_d = sptr_d;
            WR, FILL: begin
                addr_d = dptr_d;
                we_d   = 1'b1;
            end
            default: addr_d = spm_addr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sptr_q   <= '0;
            dptr_q   <= '0;
            rem_q    <= '0;
            spm_addr <= '0;
            spm_we   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sptr_q   <= sptr_d;
            dptr_q   <= dptr_d;
            rem_q    <= rem_d;
            spm_addr <= addr_d;
            spm_we   <= we_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (wr && !busy) begin
                unique case (reg_addr)
                    2'd1:    src_q <= reg_wdata;
                    2'd2:    dst_q <= reg_wdata[ADDR_W-1:0];
                    2'd3:    cnt_q <= reg_wdata[ADDR_W:0];
                    default: mode_q <= reg_wdata[1];
                endcase
            end
            if (ctrl_wr) irq_en_q <= reg_wdata[2];
            // Start beats done-clear in the same write.
            if (start)
                done_q <= (cnt_q == '0);
            else if (abort || fin)
                done_q <= 1'b1;
            else if (ctrl_wr && reg_wdata[3])
                done_q <= 1'b0;
        end
    end

    always_comb begin
        reg_rdata = '0;
        unique case (reg_addr)
            2'd0: reg_rdata = {{(DATA_W-4){1'b0}},
                               done_q, irq_en_q, mode_q, busy};
            2'd1: reg_rdata = src_q;
            2'd2: reg_rdata = {{(DATA_W-ADDR_W){1'b0}}, dst_q};
            default: reg_rdata = {{(DATA_W-ADDR_W-1){1'b0}}, cnt_q};
        endcase
    end

endmodule

// File: tb/tb_spm_xfer_engine.sv
// Bench for spm_xfer_engine: RAM model on port B, write scoreboard,
// register-level scenarios for fill, copy, wrap, zero count, abort, reset.
module tb_spm_xfer_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_cs = 1'b0, reg_we = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic [11:0] spm_addr;
    logic        spm_we;
    logic [31:0] spm_wdata;
    logic [31:0] spm_rdata = '0;
    logic        busy, irq;

    logic [31:0] mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    logic [43:0] exp_q[$];
    logic [43:0] obs_q[$];
    int          busy_cnt;
    int          n_tests = 0;
    int          n_fail = 0;

    spm_xfer_engine dut (
        .clk(clk), .reset(reset),
        .reg_cs(reg_cs), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .spm_addr(spm_addr), .spm_we(spm_we),
        .spm_wdata(spm_wdata), .spm_rdata(spm_rdata),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    // Port-B RAM: read-first, registered read data.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (spm_we) mem[spm_addr] <= spm_wdata;
        spm_rdata <= mem[spm_addr];
    end

    always @(negedge clk) begin
        if (spm_we) obs_q.push_back({spm_addr, spm_wdata});
        if (busy) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_cs = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk);
        #1;
        reg_cs = 1'b0; reg_we = 1'b0; reg_wdata = '0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        reg_cs = 1'b1; reg_we = 1'b0; reg_addr = a;
        #1;
        d = reg_rdata;
        reg_cs = 1'b0;
    endtask

    task automatic bd_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        logic [43:0] e, o;
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_wr_count got=%0d want=%0d",
                     name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s_wr got=%h/%h want=%h/%h",
                         name, o[43:32], o[31:0], e[43:32], e[31:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset;
        logic [31:0] d;
        n_tests++;
        if ({spm_addr, spm_we, busy, irq} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outs got=%h/%b/%b/%b want=0",
                     spm_addr, spm_we, busy, irq);
        end
        for (int a = 0; a < 4; a++) begin
            reg_rd(2'(a), d);
            n_tests++;
            if (d !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_reg%0d got=%h want=0", a, d);
            end
        end
    endtask

    task automatic test_fill;
        logic [31:0] d;
        bit ok;
        reg_wr(2'd1, 32'hDEADBEEF);
        reg_wr(2'd2, 32'h010);
        reg_wr(2'd3, 32'd4);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({12'h010 + 12'(i), 32'hDEADBEEF});
        busy_cnt = 0;
        reg_wr(2'd0, 32'h3);
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fill_idle got=busy want=idle");
        end
        drain("fill");
        n_tests++;
        if (busy_cnt !== 4) begin
            n_fail++;
            $display("FAIL fill_busy got=%0d want=4", busy_cnt);
        end
        reg_rd(2'd0, d);
        n_tests++;
        if (d !== 32'hA || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ctrl got=%h/%b want=a/0", d, irq);
        end
        n_tests++;
        if (mem[12'h013] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fill_mem got=%h want=deadbeef", mem[12'h013]);
        end
    endtask

    task automatic test_copy;
        bit ok;
        for (int i = 0; i < 3; i++)
            bd_wr(12'h100 + 12'(i), 32'(i + 1));
        reg_wr(2'd1, 32'h100);
        reg_wr(2'd2, 32'h200);
        reg_wr(2'd3, 32'd3);
        for (int i = 0; i < 3; i++)
            exp_q.push_back({12'h200 + 12'(i), 32'(i + 1)});
        busy_cnt = 0;
        reg_wr(2'd0, 32'h5);
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL copy_idle got=busy want=idle");
        end
        drain("copy");
        n_tests++;
        if (busy_cnt !== 6) begin
            n_fail++;
            $display("FAIL copy_busy got=%0d want=6", busy_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (mem[12'h200 + 12'(i)] !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL copy_mem%0d got=%h want=%h",
                         i, mem[12'h200 + 12'(i)], i + 1);
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL copy_irq got=%b want=1", irq);
        end
        reg_wr(2'd0, 32'hC);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL copy_irq_clr got=%b want=0", irq);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        bd_wr(12'hFFE, 32'hA0);
        bd_wr(12'hFFF, 32'hA1);
        bd_wr(12'h000, 32'hA2);
        bd_wr(12'h001, 32'hA3);
        reg_wr(2'd1, 32'hFFE);
        reg_wr(2'd2, 32'h000);
        reg_wr(2'd3, 32'd4);
        exp_q.push_back({12'h000, 32'hA0});
        exp_q.push_back({12'h001, 32'hA1});
        exp_q.push_back({12'h002, 32'hA0});
        exp_q.push_back({12'h003, 32'hA1});
        reg_wr(2'd0, 32'h1);
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrap_idle got=busy want=idle");
        end
        drain("wrap");
        n_tests++;
        if (mem[12'h002] !== 32'hA0) begin
            n_fail++;
            $display("FAIL wrap_mem2 got=%h want=a0", mem[12'h002]);
        end
    endtask

    task automatic test_cnt0;
        logic [31:0] d;
        reg_wr(2'd0, 32'h8);
        reg_rd(2'd0, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL cnt0_pre got=%h want=0", d);
        end
        reg_wr(2'd3, 32'd0);
        busy_cnt = 0;
        reg_wr(2'd0, 32'h1);
        reg_rd(2'd0, d);
        n_tests++;
        if (d !== 32'h8) begin
            n_fail++;
            $display("FAIL cnt0_done got=%h want=8", d);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy_cnt !== 0) begin
            n_fail++;
            $display("FAIL cnt0_busy got=%0d want=0", busy_cnt);
        end
        drain("cnt0");
    endtask

    task automatic test_abort;
        logic [31:0] d;
        int n;
        logic [43:0] e, o;
        reg_wr(2'd1, 32'h55);
        reg_wr(2'd2, 32'h300);
        reg_wr(2'd3, 32'd8);
        for (int i = 0; i < 3; i++)
            exp_q.push_back({12'h300 + 12'(i), 32'h55});
        reg_wr(2'd0, 32'h3);
        reg_wr(2'd2, 32'h777);
        reg_wr(2'd0, 32'h1);
        reg_wr(2'd0, 32'h10);
        n_tests++;
        if (spm_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop got=%b/%b want=0/0", spm_we, busy);
        end
        repeat (4) @(negedge clk);
        n = obs_q.size();
        n_tests++;
        if (n < 2 || n > 3) begin
            n_fail++;
            $display("FAIL abort_wr_count got=%0d want=2..3", n);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_wr got=%h want=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        reg_rd(2'd0, d);
        n_tests++;
        if (d !== 32'hA) begin
            n_fail++;
            $display("FAIL abort_ctrl got=%h want=a", d);
        end
        reg_rd(2'd2, d);
        n_tests++;
        if (d !== 32'h300) begin
            n_fail++;
            $display("FAIL abort_dst got=%h want=300", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        reg_wr(2'd1, 32'h100);
        reg_wr(2'd2, 32'h400);
        reg_wr(2'd3, 32'd8);
        reg_wr(2'd0, 32'h5);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({spm_addr, spm_we, busy, irq} !== 15'd0) begin
            n_fail++;
            $display("FAIL rstmid_outs got=%h/%b/%b/%b want=0",
                     spm_addr, spm_we, busy, irq);
        end
        @(negedge clk);
        reset = 1'b1;
        reg_rd(2'd0, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl got=%h want=0", d);
        end
        reg_rd(2'd3, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_cnt got=%h want=0", d);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        busy_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_cnt0();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
